// File: rtl/mem_req_queue.sv
// mem_req_queue
//
// Data-memory request unit for the memory stage of the pipelined core.
// It accepts load/store requests from execute/mem into a one-entry hold
// register and presents them to data memory. It tracks up to max_out_p
// issued-but-unanswered operations in a small in-order FIFO. Each memory
// response is matched against the FIFO head: load results are tagged with
// their destination register and go to writeback, and store acks are
// absorbed silently. A fence input holds off new requests until the unit
// has fully drained.
//
// Ports
//   clk, reset          clock; asynchronous active-low reset
//   req_*_i / req_ready_o   request from the core (valid/ready)
//   fence_i             block acceptance until hold register and FIFO are empty
//   to_mem_*_o          request to memory, driven straight from the hold register
//   mem_yumi_i          memory takes the presented request
//   mem_valid_i/data_i  in-order memory response
//   to_mem_yumi_o       unit consumes the current response
//   resp_*_o            load result to writeback
//   resp_ready_i        writeback can take a result this cycle
//   stall_o             request present but not accepted
//   busy_o              hold register valid or operations outstanding
//   count_o             issued-outstanding count
//   err_o               sticky: response arrived with nothing outstanding
module mem_req_queue #(
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32,
    parameter int tag_width_p  = 5,
    parameter int max_out_p    = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              req_valid_i,
    input  logic                              req_wen_i,
    input  logic                              req_byte_i,
    input  logic [addr_width_p-1:0]           req_addr_i,
    input  logic [data_width_p-1:0]           req_data_i,
    input  logic [tag_width_p-1:0]            req_tag_i,
    output logic                              req_ready_o,
    input  logic                              fence_i,
    output logic                              to_mem_valid_o,
    output logic                              to_mem_wen_o,
    output logic                              to_mem_byte_o,
    output logic [addr_width_p-1:0]           to_mem_addr_o,
    output logic [data_width_p-1:0]           to_mem_data_o,
    input  logic                              mem_yumi_i,
    input  logic                              mem_valid_i,
    input  logic [data_width_p-1:0]           mem_data_i,
    output logic                              to_mem_yumi_o,
    output logic                              resp_valid_o,
    output logic [data_width_p-1:0]           resp_data_o,
    output logic [tag_width_p-1:0]            resp_tag_o,
    input  logic                              resp_ready_i,
    output logic                              stall_o,
    output logic                              busy_o,
    output logic [$clog2(max_out_p+1)-1:0]    count_o,
    output logic                              err_o
);

    localparam int CW = $clog2(max_out_p + 1);
    localparam int PW = $clog2(max_out_p);
    localparam int EW = tag_width_p + 2;
    localparam logic [CW:0] MAX_OUT_C = (CW+1)'(max_out_p);

    // hold register
    logic                    hold_v_q,    hold_v_d;
    logic                    hold_wen_q,  hold_wen_d;
    logic                    hold_byte_q, hold_byte_d;
    logic [addr_width_p-1:0] hold_addr_q, hold_addr_d;
    logic [data_width_p-1:0] hold_data_q, hold_data_d;
    logic [tag_width_p-1:0]  hold_tag_q,  hold_tag_d;

    // tracking FIFO
    logic [EW-1:0]           fifo_q [max_out_p];
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q,  count_d;
    logic                    err_q,    err_d;

    logic                    accept;
    logic                    push;
    logic                    pop;
    logic                    fifo_empty;
    logic                    fence_blk;
    logic [CW:0]             occupancy;
    logic [EW-1:0]           head;
    logic                    head_wen;
    logic                    head_byte;
    logic [tag_width_p-1:0]  head_tag;

    // Credit check uses the registered count only; a response popping this
    // cycle does not free a slot until the next cycle.
    assign occupancy   = {1'b0, count_q} + (CW+1)'(hold_v_q);
    assign fence_blk   = fence_i & (hold_v_q | (count_q != '0));
    assign req_ready_o = ~fence_blk & (~hold_v_q | mem_yumi_i) & (occupancy < MAX_OUT_C);
    assign accept      = req_valid_i & req_ready_o;
    assign push        = hold_v_q & mem_yumi_i;
    assign stall_o     = req_valid_i & ~req_ready_o;

    assign to_mem_valid_o = hold_v_q;
    assign to_mem_wen_o   = hold_wen_q;
    assign to_mem_byte_o  = hold_byte_q;
    assign to_mem_addr_o  = hold_addr_q;
    assign to_mem_data_o  = hold_data_q;

    assign fifo_empty = (count_q == '0);
    assign head       = fifo_q[rd_ptr_q];
    assign head_wen   = head[EW-1];
    assign head_byte  = head[EW-2];
    assign head_tag   = head[tag_width_p-1:0];

    assign resp_tag_o  = head_tag;
    assign resp_data_o = head_byte ? {{(data_width_p-8){1'b0}}, mem_data_i[7:0]} : mem_data_i;
    assign busy_o      = hold_v_q | ~fifo_empty;
    assign count_o     = count_q;
    assign err_o       = err_q;

    always_comb begin
        hold_v_d    = hold_v_q;
        hold_wen_d  = hold_wen_q;
        hold_byte_d = hold_byte_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        hold_tag_d  = hold_tag_q;
        if (accept) begin
            hold_v_d    = 1'b1;
            hold_wen_d  = req_wen_i;
            hold_byte_d = req_byte_i;
            hold_addr_d = req_addr_i;
            hold_data_d = req_data_i;
            hold_tag_d  = req_tag_i;
        end else if (push) begin
            hold_v_d = 1'b0;
        end
    end

    // Response matching against the FIFO head.
    always_comb begin
        to_mem_yumi_o = 1'b0;
        resp_valid_o  = 1'b0;
        pop           = 1'b0;
        err_d         = err_q;
        if (mem_valid_i) begin
            if (fifo_empty) begin
                // stray response: drain it and flag the protocol error
                to_mem_yumi_o = 1'b1;
                err_d         = 1'b1;
            end else if (head_wen) begin
                to_mem_yumi_o = 1'b1;
                pop           = 1'b1;
            end else begin
                resp_valid_o  = 1'b1;
                to_mem_yumi_o = resp_ready_i;
                pop           = resp_ready_i;
            end
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_v_q    <= 1'b0;
            hold_wen_q  <= 1'b0;
            hold_byte_q <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            hold_tag_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            hold_v_q    <= hold_v_d;
            hold_wen_q  <= hold_wen_d;
            hold_byte_q <= hold_byte_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            hold_tag_q  <= hold_tag_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_q       <= err_d;
        end
    end

    // Entry storage needs no reset: an entry is only read once count shows it valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {hold_wen_q, hold_byte_q, hold_tag_q};
        end
    end

endmodule

// File: tb/tb_mem_req_queue.sv
module tb_mem_req_queue;

    logic        clk;
    logic        reset;
    logic        req_valid_i, req_wen_i, req_byte_i;
    logic [31:0] req_addr_i, req_data_i;
    logic [4:0]  req_tag_i;
    logic        req_ready_o;
    logic        fence_i;
    logic        to_mem_valid_o, to_mem_wen_o, to_mem_byte_o;
    logic [31:0] to_mem_addr_o, to_mem_data_o;
    logic        mem_yumi_i, mem_valid_i;
    logic [31:0] mem_data_i;
    logic        to_mem_yumi_o;
    logic        resp_valid_o;
    logic [31:0] resp_data_o;
    logic [4:0]  resp_tag_o;
    logic        resp_ready_i;
    logic        stall_o, busy_o;
    logic [2:0]  count_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    mem_req_queue #(
        .addr_width_p(32), .data_width_p(32), .tag_width_p(5), .max_out_p(4)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid_i), .req_wen_i(req_wen_i), .req_byte_i(req_byte_i),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_tag_i(req_tag_i),
        .req_ready_o(req_ready_o), .fence_i(fence_i),
        .to_mem_valid_o(to_mem_valid_o), .to_mem_wen_o(to_mem_wen_o),
        .to_mem_byte_o(to_mem_byte_o), .to_mem_addr_o(to_mem_addr_o),
        .to_mem_data_o(to_mem_data_o), .mem_yumi_i(mem_yumi_i),
        .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i),
        .to_mem_yumi_o(to_mem_yumi_o), .resp_valid_o(resp_valid_o),
        .resp_data_o(resp_data_o), .resp_tag_o(resp_tag_o),
        .resp_ready_i(resp_ready_i), .stall_o(stall_o), .busy_o(busy_o),
        .count_o(count_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input logic v, input logic w, input logic b,
                           input logic [31:0] a, input logic [31:0] d, input logic [4:0] t);
        req_valid_i = v;
        req_wen_i   = w;
        req_byte_i  = b;
        req_addr_i  = a;
        req_data_i  = d;
        req_tag_i   = t;
    endtask

    initial begin
        reset        = 1'b0;
        set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        fence_i      = 1'b0;
        mem_yumi_i   = 1'b0;
        mem_valid_i  = 1'b0;
        mem_data_i   = 32'h0;
        resp_ready_i = 1'b1;

        // reset state
        #2;
        chk("rst_count",    32'(count_o), 0);
        chk("rst_busy",     32'(busy_o), 0);
        chk("rst_to_mem_v", 32'(to_mem_valid_o), 0);
        chk("rst_err",      32'(err_o), 0);
        chk("rst_resp_v",   32'(resp_valid_o), 0);
        chk("rst_ready",    32'(req_ready_o), 1);
        req_valid_i = 1'b0;
        #10;
        reset = 1'b1;
        tick();

        // single load, tag 3, addr 0x40
        set_req(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 5'd3);
        settle();
        chk("ld_ready", 32'(req_ready_o), 1);
        chk("ld_stall", 32'(stall_o), 0);
        tick();
        req_valid_i = 1'b0;
        mem_yumi_i  = 1'b1;
        settle();
        chk("ld_to_mem_v",    32'(to_mem_valid_o), 1);
        chk("ld_to_mem_addr", to_mem_addr_o, 32'h40);
        chk("ld_to_mem_wen",  32'(to_mem_wen_o), 0);
        chk("ld_count0",      32'(count_o), 0);
        tick();
        mem_yumi_i = 1'b0;
        settle();
        chk("ld_count1",   32'(count_o), 1);
        chk("ld_hold_gone", 32'(to_mem_valid_o), 0);
        tick();
        mem_valid_i = 1'b1;
        mem_data_i  = 32'h12345678;
        settle();
        chk("ld_resp_v",    32'(resp_valid_o), 1);
        chk("ld_resp_tag",  32'(resp_tag_o), 3);
        chk("ld_resp_data", resp_data_o, 32'h12345678);
        chk("ld_yumi",      32'(to_mem_yumi_o), 1);
        tick();
        mem_valid_i = 1'b0;
        settle();
        chk("ld_count_end", 32'(count_o), 0);
        chk("ld_busy_end",  32'(busy_o), 0);

        // back-to-back to full: L(tag1), S, L(tag2), S, then a rejected fifth
        mem_yumi_i = 1'b1;
        set_req(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 5'd1);
        settle();
        chk("b2b_ready0", 32'(req_ready_o), 1);
        tick();
        set_req(1'b1, 1'b1, 1'b0, 32'h104, 32'hAA, 5'd0);
        settle();
        chk("b2b_ready1", 32'(req_ready_o), 1);
        chk("b2b_hold_addr0", to_mem_addr_o, 32'h100);
        tick();
        set_req(1'b1, 1'b0, 1'b0, 32'h108, 32'h0, 5'd2);
        settle();
        chk("b2b_ready2", 32'(req_ready_o), 1);
        chk("b2b_hold_data1", to_mem_data_o, 32'hAA);
        chk("b2b_hold_wen1",  32'(to_mem_wen_o), 1);
        tick();
        set_req(1'b1, 1'b1, 1'b0, 32'h10C, 32'hBB, 5'd0);
        settle();
        chk("b2b_ready3", 32'(req_ready_o), 1);
        tick();
        set_req(1'b1, 1'b0, 1'b0, 32'h110, 32'h0, 5'd9);
        settle();
        chk("b2b_ready4", 32'(req_ready_o), 0);
        chk("b2b_stall4", 32'(stall_o), 1);
        chk("b2b_count3", 32'(count_o), 3);
        tick();
        req_valid_i = 1'b0;
        mem_yumi_i  = 1'b0;
        settle();
        chk("b2b_count_full", 32'(count_o), 4);
        chk("b2b_full_ready", 32'(req_ready_o), 0);
        chk("b2b_hold_empty", 32'(to_mem_valid_o), 0);

        // responses in order
        mem_valid_i = 1'b1;
        mem_data_i  = 32'h11111111;
        settle();
        chk("r1_valid", 32'(resp_valid_o), 1);
        chk("r1_tag",   32'(resp_tag_o), 1);
        chk("r1_data",  resp_data_o, 32'h11111111);
        chk("r1_yumi",  32'(to_mem_yumi_o), 1);
        tick();
        mem_data_i = 32'h22222222;
        settle();
        chk("r2_store_valid", 32'(resp_valid_o), 0);
        chk("r2_store_yumi",  32'(to_mem_yumi_o), 1);
        tick();
        // writeback backpressure on the second load
        resp_ready_i = 1'b0;
        mem_data_i   = 32'h33333333;
        settle();
        chk("r3_valid",     32'(resp_valid_o), 1);
        chk("r3_tag",       32'(resp_tag_o), 2);
        chk("r3_bp_yumi",   32'(to_mem_yumi_o), 0);
        chk("r3_count_pre", 32'(count_o), 2);
        tick();
        chk("r3_count_held", 32'(count_o), 2);
        chk("r3_valid_held", 32'(resp_valid_o), 1);
        resp_ready_i = 1'b1;
        settle();
        chk("r3_yumi", 32'(to_mem_yumi_o), 1);
        tick();
        mem_data_i = 32'h44444444;
        settle();
        chk("r4_count",       32'(count_o), 1);
        chk("r4_store_valid", 32'(resp_valid_o), 0);
        chk("r4_store_yumi",  32'(to_mem_yumi_o), 1);
        tick();
        mem_valid_i = 1'b0;
        settle();
        chk("b2b_drained", 32'(count_o), 0);
        chk("b2b_busy",    32'(busy_o), 0);

        // byte load
        mem_yumi_i = 1'b1;
        set_req(1'b1, 1'b0, 1'b1, 32'h41, 32'h0, 5'd7);
        tick();
        req_valid_i = 1'b0;
        settle();
        chk("byte_to_mem_byte", 32'(to_mem_byte_o), 1);
        tick();
        mem_yumi_i  = 1'b0;
        mem_valid_i = 1'b1;
        mem_data_i  = 32'hDEADBEEF;
        settle();
        chk("byte_data", resp_data_o, 32'h000000EF);
        chk("byte_tag",  32'(resp_tag_o), 7);
        tick();
        mem_valid_i = 1'b0;

        // fence with two loads outstanding
        mem_yumi_i = 1'b1;
        set_req(1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 5'd4);
        tick();
        set_req(1'b1, 1'b0, 1'b0, 32'h204, 32'h0, 5'd5);
        tick();
        req_valid_i = 1'b0;
        tick();
        settle();
        chk("fence_count2", 32'(count_o), 2);
        fence_i = 1'b1;
        set_req(1'b1, 1'b0, 1'b0, 32'h208, 32'h0, 5'd6);
        settle();
        chk("fence_stall_a", 32'(stall_o), 1);
        mem_valid_i = 1'b1;
        mem_data_i  = 32'h55;
        settle();
        chk("fence_stall_b", 32'(stall_o), 1);
        chk("fence_r_tag4",  32'(resp_tag_o), 4);
        tick();
        settle();
        chk("fence_stall_c", 32'(stall_o), 1);
        chk("fence_count1",  32'(count_o), 1);
        chk("fence_r_tag5",  32'(resp_tag_o), 5);
        tick();
        mem_valid_i = 1'b0;
        settle();
        chk("fence_count0", 32'(count_o), 0);
        chk("fence_ready",  32'(req_ready_o), 1);
        chk("fence_nostall", 32'(stall_o), 0);
        tick();
        fence_i     = 1'b0;
        req_valid_i = 1'b0;
        settle();
        chk("fence_issue_v",    32'(to_mem_valid_o), 1);
        chk("fence_issue_addr", to_mem_addr_o, 32'h208);
        tick();
        mem_yumi_i  = 1'b0;
        mem_valid_i = 1'b1;
        settle();
        chk("fence_last_tag", 32'(resp_tag_o), 6);
        tick();
        mem_valid_i = 1'b0;
        settle();
        chk("fence_drained", 32'(count_o), 0);

        // stray response -> sticky error
        mem_valid_i = 1'b1;
        mem_data_i  = 32'h99;
        settle();
        chk("err_yumi",    32'(to_mem_yumi_o), 1);
        chk("err_resp_v",  32'(resp_valid_o), 0);
        chk("err_pre",     32'(err_o), 0);
        tick();
        mem_valid_i = 1'b0;
        settle();
        chk("err_set", 32'(err_o), 1);
        tick();
        chk("err_sticky", 32'(err_o), 1);

        // reset mid-burst
        mem_yumi_i = 1'b1;
        set_req(1'b1, 1'b1, 1'b0, 32'h300, 32'h1, 5'd0);
        tick();
        set_req(1'b1, 1'b1, 1'b0, 32'h304, 32'h2, 5'd0);
        tick();
        settle();
        chk("burst_count", 32'(count_o), 1);
        chk("burst_busy",  32'(busy_o), 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_err",   32'(err_o), 0);
        chk("mid_rst_count", 32'(count_o), 0);
        chk("mid_rst_busy",  32'(busy_o), 0);
        chk("mid_rst_to_mem", 32'(to_mem_valid_o), 0);
        req_valid_i = 1'b0;
        mem_yumi_i  = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        // late response for a discarded op is a protocol error
        mem_valid_i = 1'b1;
        settle();
        chk("late_yumi", 32'(to_mem_yumi_o), 1);
        tick();
        mem_valid_i = 1'b0;
        settle();
        chk("late_err", 32'(err_o), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
